fp_norm_round: RTL

FP_NORM_ROUND -- requirements
Module: fp_norm_round

---
 rtl/fp_norm_round.sv | 321 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_norm_round.sv
// ---------------------------------------------------------------------------
// fp_norm_round
//
// Normalise and round stage that follows a binary32 add/sub datapath.
// It takes the raw magnitude sum, carry-out and guard/round/sticky bits from
// the adder, normalises the significand, applies a RISC-V rounding mode and
// produces an IEEE-754 binary32 result. The overflow saturation value depends
// on the rounding mode.
//
// One operand is processed at a time by a four-state FSM:
//   IDLE  : in_ready=1; the operand is captured on in_valid & in_ready
//   NORM  : leading-zero count, shift, exponent adjust
//   ROUND : increment decision, carry fix-up, saturation
//   DONE  : out_valid=1; result is held until out_ready
//
// Ports
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset (flushes any operand in flight)
//   in_valid      upstream add/sub result valid
//   in_ready      block can accept a new operand (IDLE only)
//   sign_res      sign of the add/sub result
//   carry         add/sub carry-out (sum bit 48)
//   mantissa_sum  48-bit magnitude; the hidden bit is at [47] when carry=0
//   grs           guard/round/sticky from add/sub
//   exp_in        larger biased operand exponent
//   rm            rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM;
//                 101-111 behave as RNE)
//   out_valid     result valid
//   out_ready     downstream accepts the result
//   result        IEEE-754 binary32 result
//   fflags        {NV,DZ,OF,UF,NX}, present only with FP_NORM_FLAGS_EN
//
// Build option
//   FP_NORM_FLAGS_EN : when defined, adds the fflags output and its logic.
// ---------------------------------------------------------------------------
module fp_norm_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_res,
  input  logic        carry,
  input  logic [47:0] mantissa_sum,
  input  logic [2:0]  grs,
  input  logic [7:0]  exp_in,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
`ifdef FP_NORM_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  state_t state_q;
  state_t state_d;
  logic   accept;

  // Captured operand
  logic        sign_q;
  logic        carry_q;
  logic [47:0] msum_q;
  logic [2:0]  grs_q;
  logic [7:0]  exp_q;
  logic [2:0]  rm_q;

  // Normalisation stage results
  logic [7:0]  lz;
  logic [7:0]  lz_max;
  logic        clamp;
  logic [7:0]  sh_amt;
  logic [47:0] shifted;
  logic [23:0] n_sig;
  logic [9:0]  n_exp;
  logic        n_g;
  logic        n_r;
  logic        n_s;
  logic        n_zero;

  logic [23:0] sig_q;
  logic [9:0]  nexp_q;
  logic        g_q;
  logic        r_q;
  logic        s_q;
  logic        zero_q;

  // Rounding stage
  logic [2:0]  rm_eff;
  logic        any_lost;
  logic        inc;
  logic [24:0] sum25;
  logic        bump;
  logic [9:0]  fexp;
  logic [22:0] mant;
  logic        sat;
  logic [31:0] round_res;

  // Leading-zero count of a 48-bit vector; an all-zero input yields 48.
  function automatic logic [7:0] lzc48(input logic [47:0] v);
    logic [7:0] n;
    logic       found;
    n     = 8'd48;
    found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 8'(47 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = NORM;
        end
      end
      NORM: begin
        state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture: upstream is free to change its outputs after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      msum_q  <= 48'd0;
      grs_q   <= 3'd0;
      exp_q   <= 8'd0;
      rm_q    <= 3'd0;
    end else if (accept) begin
      sign_q  <= sign_res;
      carry_q <= carry;
      msum_q  <= mantissa_sum;
      grs_q   <= grs;
      exp_q   <= exp_in;
      rm_q    <= rm;
    end
  end

  // The left shift may not push the exponent below 1; when the leading-zero
  // count exceeds that limit the value stays denormalised and the exponent
  // field becomes 0.
  assign lz      = lzc48(msum_q);
  assign lz_max  = (exp_q == 8'd0) ? 8'd0 : exp_q - 8'd1;
  assign clamp   = lz > lz_max;
  assign sh_amt  = clamp ? lz_max : lz;
  assign shifted = msum_q << sh_amt;

  // Normalisation: carry-out shifts right, hidden bit in place passes
  // through, otherwise shift left. Only the shift path rebuilds G/R/S from
  // the shifted magnitude, keeping the incoming sticky.
  always_comb begin
    n_sig  = 24'd0;
    n_exp  = 10'd0;
    n_g    = 1'b0;
    n_r    = 1'b0;
    n_s    = 1'b0;
    n_zero = ~carry_q & (msum_q == 48'd0) & (grs_q == 3'd0);
    if (carry_q) begin
      n_sig = {1'b1, msum_q[47:25]};
      n_exp = {2'b00, exp_q} + 10'd1;
      n_g   = grs_q[2];
      n_r   = grs_q[1];
      n_s   = grs_q[0];
    end else if (msum_q[47]) begin
      n_sig = msum_q[47:24];
      n_exp = {2'b00, exp_q};
      n_g   = grs_q[2];
      n_r   = grs_q[1];
      n_s   = grs_q[0];
    end else begin
      n_sig = shifted[47:24];
      n_exp = clamp ? 10'd0 : ({2'b00, exp_q} - {2'b00, sh_amt});
      n_g   = shifted[23];
      n_r   = shifted[22];
      n_s   = (|shifted[21:0]) | grs_q[0];
    end
  end

  // Normalisation register, loaded on the NORM cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 24'd0;
      nexp_q <= 10'd0;
      g_q    <= 1'b0;
      r_q    <= 1'b0;
      s_q    <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == NORM) begin
      sig_q  <= n_sig;
      nexp_q <= n_exp;
      g_q    <= n_g;
      r_q    <= n_r;
      s_q    <= n_s;
      zero_q <= n_zero;
    end
  end

  // Reserved rounding-mode encodings fall back to round-to-nearest-even
  always_comb begin
    case (rm_q)
      RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: rm_eff = rm_q;
      default:                                rm_eff = RM_RNE;
    endcase
  end

  assign any_lost = g_q | r_q | s_q;

  // Increment decision
  always_comb begin
    case (rm_eff)
      RM_RNE:  inc = g_q & (r_q | s_q | sig_q[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q & any_lost;
      RM_RUP:  inc = ~sign_q & any_lost;
      RM_RMM:  inc = g_q;
      default: inc = g_q & (r_q | s_q | sig_q[0]);
    endcase
  end

  // The exponent steps up either on a significand carry-out or when a
  // subnormal rounds up into the smallest normal (hidden bit appears).
  assign sum25 = {1'b0, sig_q} + {24'd0, inc};
  assign bump  = sum25[24] | (sum25[23] & ~sig_q[23]);
  assign fexp  = nexp_q + {9'd0, bump};
  assign mant  = sum25[24] ? sum25[23:1] : sum25[22:0];
  assign sat   = fexp >= 10'd255;

  // Final packing, with mode-dependent overflow values and signed zero
  always_comb begin
    round_res = {sign_q, fexp[7:0], mant};
    if (zero_q) begin
      round_res = {(rm_eff == RM_RDN), 31'd0};
    end else if (sat) begin
      case (rm_eff)
        RM_RTZ:  round_res = {sign_q, 8'hFE, 23'h7FFFFF};
        RM_RDN:  round_res = sign_q ? {1'b1, 8'hFF, 23'h0} : {1'b0, 8'hFE, 23'h7FFFFF};
        RM_RUP:  round_res = sign_q ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'h0};
        default: round_res = {sign_q, 8'hFF, 23'h0};
      endcase
    end
  end

  // Result register, written as the FSM leaves ROUND and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= 32'd0;
    end else if (state_q == ROUND) begin
      result <= round_res;
    end
  end

`ifdef FP_NORM_FLAGS_EN
  logic       f_of;
  logic       f_nx;
  logic       f_uf;
  logic [4:0] flags_d;

  // Underflow is reported only for inexact results left subnormal or zero
  assign f_of    = sat & ~zero_q;
  assign f_nx    = (any_lost | f_of) & ~zero_q;
  assign f_uf    = f_nx & ~sat & (fexp[7:0] == 8'd0);
  assign flags_d = {2'b00, f_of, f_uf, f_nx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= 5'd0;
    end else if (state_q == ROUND) begin
      fflags <= flags_d;
    end
  end
`endif

endmodule
